// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and bit-timing helpers shared by the uart transmitter
// and receiver. The PARITY state is only entered when UART_RX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_state_e;

  // Clocks per bit period, integer truncated.
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

  // Offset from the start-bit edge to the middle of the start bit.
  function automatic int half_bit(input int freq, input int baud);
    return clks_per_bit(freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small synchronous FIFO with extra-MSB pointers.
// Head data is read straight from storage; a push while full is dropped
// unless a pop frees the slot in the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]                 wr_ptr_q, wr_ptr_d;
  logic [AW:0]                 rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic                        do_push, do_pop;

  // Status, pointer advance and storage write.
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_d     = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    head_data = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Storage is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined)
// feeding a byte FIFO with a data_ready / read_ack handshake.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_data_ready,
  input  logic       rx_read_ack,
  output logic       rx_overrun,
  output logic       rx_frame_error
);

  localparam int          CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int          HALF_BIT     = half_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam logic [15:0] CLKS_M1      = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1      = 16'(HALF_BIT - 1);

  uart_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        meta_q, meta_d;
  logic        rx_s_q, rx_s_d;
  logic        overrun_q, overrun_d;
  logic        frame_err_q, frame_err_d;
  logic        push, discard;
  logic        fifo_empty, fifo_full;
`ifdef UART_RX_PARITY_EN
  logic        bad_q, bad_d;
`endif

  // Receive FSM: the counter counts down to the next sample point and is
  // reloaded whenever the state changes.
  always_comb begin
    meta_d      = uart_rx_pin;
    rx_s_d      = meta_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    bad_d   = bad_q;
    discard = bad_q;
`else
    discard = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = HALF_M1;
        if (!rx_s_q) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == 16'd0) begin
          cnt_d     = CLKS_M1;
          bit_idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
          bad_d     = 1'b0;
`endif
          // A line that is high again mid start bit was a glitch.
          state_d   = rx_s_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == 16'd0) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          cnt_d     = CLKS_M1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = CLKS_M1;
          state_d = ST_STOP;
          // Even parity: data plus parity bit must XOR to zero.
          if (^{shift_q, rx_s_q}) begin
            frame_err_d = 1'b1;
            bad_d       = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == 16'd0) begin
          cnt_d = HALF_M1;
          if (rx_s_q) begin
            push    = !discard;
            state_d = ST_IDLE;
          end else begin
            // A frame already flagged for parity does not flag again.
            frame_err_d = !discard;
            state_d     = ST_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = HALF_M1;
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = HALF_M1;
        state_d = ST_IDLE;
      end
    endcase
    // Full implies non-empty, so an ack here always frees a slot.
    overrun_d = push && fifo_full && !rx_read_ack;
  end

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bad_q       <= 1'b0;
`endif
    end else begin
      meta_q      <= meta_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      bad_q       <= bad_d;
`endif
    end
  end

  uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shift_q),
    .pop       (rx_read_ack),
    .head_data (rx_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign rx_data_ready  = !fifo_empty;
  assign rx_overrun     = overrun_q;
  assign rx_frame_error = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenarios plus randomized frames checked against a
// queue model of the receive FIFO and expected flag counts.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_HZ = 27000000;
  localparam int BAUD   = 115200;
  localparam int DEPTH  = 8;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int HB     = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS  = 10;
`else
  localparam int NBITS  = 9;
`endif
  // Stop sample relative to rx_s low, plus one cycle to reach the output.
  localparam int NOM_LAT  = HB + NBITS * CPB + 1;
  // Pin fall to stop-sample cycle, including the 2-cycle synchronizer.
  localparam int STOP_CYC = 2 + HB + NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rx_pin;
  logic [7:0] rx_data;
  logic       rx_data_ready;
  logic       rx_read_ack;
  logic       rx_overrun;
  logic       rx_frame_error;

  uart_rx #(
    .CLOCK_FREQUENCY (CLK_HZ),
    .BAUD_RATE       (BAUD),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .uart_rx_pin    (uart_rx_pin),
    .rx_data        (rx_data),
    .rx_data_ready  (rx_data_ready),
    .rx_read_ack    (rx_read_ack),
    .rx_overrun     (rx_overrun),
    .rx_frame_error (rx_frame_error)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         fall_cyc, rise_cyc;
  int         ovr_cnt = 0, ferr_cnt = 0;
  int         exp_ovr = 0, exp_ferr = 0;
  logic       rdy_prev = 1'b0;
  logic [7:0] q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Count flag-high cycles, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (rx_overrun === 1'b1)     ovr_cnt++;
    if (rx_frame_error === 1'b1) ferr_cnt++;
    if (rx_data_ready === 1'b1 && !rdy_prev) rise_cyc = cyc;
    rdy_prev = (rx_data_ready === 1'b1);
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bit_out(input logic v);
    uart_rx_pin = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // One frame; a bad stop bit is followed by 3 more low bit times.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
    @(posedge clk); #1;
    fall_cyc = cyc;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_out((^b) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    bit_out(stop_v);
    if (!stop_v) repeat (3) bit_out(1'b0);
    uart_rx_pin = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Reference: a clean frame lands in the queue unless it is full.
  task automatic model_frame(input logic [7:0] b, input logic good);
    if (!good) exp_ferr++;
    else if (q.size() < DEPTH) q.push_back(b);
    else exp_ovr++;
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    chk({tag, "_ovr"},  ovr_cnt,  exp_ovr);
    chk({tag, "_ferr"}, ferr_cnt, exp_ferr);
    chk({tag, "_rdy"},  rx_data_ready, (q.size() != 0));
  endtask

  task automatic pop_chk(input string tag);
    @(negedge clk);
    chk({tag, "_rdy"},  rx_data_ready, 1);
    chk({tag, "_data"}, rx_data, q[0]);
    @(posedge clk); #1 rx_read_ack = 1'b1;
    @(posedge clk); #1 rx_read_ack = 1'b0;
    void'(q.pop_front());
  endtask

  logic [7:0] rb;
  logic       rgood;
  int         npop, lat;

  initial begin
    rst_n       = 1'b0;
    uart_rx_pin = 1'b1;
    rx_read_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy",  rx_data_ready,  0);
    chk("rst_data", rx_data,        8'h00);
    chk("rst_ovr",  rx_overrun,     0);
    chk("rst_ferr", rx_frame_error, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;

    // Single byte, latency from pin fall, ack drops ready next cycle.
    send_frame(8'h55, 1'b1, 1'b0);
    model_frame(8'h55, 1'b1);
    lat = rise_cyc - fall_cyc;
    chk("single_lat_ok", (lat >= NOM_LAT - 2) && (lat <= NOM_LAT + 2), 1);
    check_state("single");
    pop_chk("single_pop");
    @(negedge clk);
    chk("single_rdy_low", rx_data_ready, 0);

    // Nine bytes without ack: the ninth overruns.
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      model_frame(8'(i), 1'b1);
    end
    check_state("ovr9");
    // Push and pop in the same cycle while full: both succeed, no overrun.
    @(negedge clk);
    chk("full_head", rx_data, q[0]);
    fork
      send_frame(8'h0A, 1'b1, 1'b0);
      begin
        @(posedge clk); #1;
        repeat (STOP_CYC) @(posedge clk);
        #1 rx_read_ack = 1'b1;
        @(posedge clk); #1 rx_read_ack = 1'b0;
      end
    join
    void'(q.pop_front());
    model_frame(8'h0A, 1'b1);
    check_state("pushpop");
    while (q.size() != 0) pop_chk("drain");
    check_state("drained");

    // Bad stop bit with the line held low: one pulse, then a clean byte.
    send_frame(8'hA3, 1'b0, 1'b0);
    model_frame(8'hA3, 1'b0);
    check_state("frame_err");
    send_frame(8'h3C, 1'b1, 1'b0);
    model_frame(8'h3C, 1'b1);
    check_state("after_ferr");
    pop_chk("after_ferr_pop");

    // Short low glitch on the idle line.
    @(posedge clk); #1 uart_rx_pin = 1'b0;
    repeat (50) @(posedge clk);
    #1 uart_rx_pin = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    check_state("glitch");

    // Reset during bit 4 with a byte already buffered.
    send_frame(8'h5A, 1'b1, 1'b0);
    model_frame(8'h5A, 1'b1);
    check_state("pre_rst");
    @(posedge clk); #1;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(rb_c7(i));
    uart_rx_pin = 1'b0;
    repeat (CPB / 2) @(posedge clk);
    #1 rst_n = 1'b0;
    uart_rx_pin = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    q.delete();
    repeat (3 * CPB) @(posedge clk);
    #1;
    check_state("mid_rst");
    chk("mid_rst_data", rx_data, 8'h00);
    send_frame(8'hC7, 1'b1, 1'b0);
    model_frame(8'hC7, 1'b1);
    check_state("post_rst");
    pop_chk("post_rst_pop");

`ifdef UART_RX_PARITY_EN
    // 8'h07 has odd weight, so a parity bit of 0 is wrong.
    send_frame(8'h07, 1'b1, 1'b1);
    model_frame(8'h07, 1'b0);
    check_state("par_bad");
    send_frame(8'h07, 1'b1, 1'b0);
    model_frame(8'h07, 1'b1);
    check_state("par_good");
    pop_chk("par_pop");
`endif

    // Random bytes, random stop-bit errors, random partial drains.
    for (int r = 0; r < 8; r++) begin
      rb    = 8'($urandom_range(0, 255));
      rgood = ($urandom_range(0, 5) != 0);
      repeat ($urandom_range(5, 200)) @(posedge clk);
      #1;
      send_frame(rb, rgood, 1'b0);
      model_frame(rb, rgood);
      check_state("rnd");
      npop = $urandom_range(0, q.size());
      repeat (npop) pop_chk("rnd_pop");
      if (q.size() == 0) begin
        @(posedge clk); #1 rx_read_ack = 1'b1;
        @(posedge clk); #1 rx_read_ack = 1'b0;
        @(negedge clk);
        chk("rnd_empty_ack", rx_data_ready, 0);
      end
    end
    while (q.size() != 0) pop_chk("final_drain");
    check_state("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  function automatic logic rb_c7(input int i);
    logic [7:0] v;
    v = 8'hC7;
    return v[i];
  endfunction

endmodule
